// File: rtl/ntsc_pkg.sv
// Shared constants, pulse classes and decoder states for the NTSC
// sync decoder: signal levels, sync-width windows, visible-area geometry.
package ntsc_pkg;

    localparam logic [3:0] SIGNAL_LEVEL_SYNC         = 4'd0;
    localparam logic [3:0] SIGNAL_LEVEL_BLANK        = 4'd1;
    localparam logic [3:0] SIGNAL_LEVEL_BLACK        = 4'd2;
    localparam logic [3:0] SIGNAL_LEVEL_DARK_GREY    = 4'd3;
    localparam logic [3:0] SIGNAL_LEVEL_GREY         = 4'd4;
    localparam logic [3:0] SIGNAL_LEVEL_LIGHT_GREY   = 4'd5;
    localparam logic [3:0] SIGNAL_LEVEL_WHITE        = 4'd6;
    localparam logic [3:0] SIGNAL_LEVEL_BRIGHT_WHITE = 4'd7;

    localparam logic [10:0] WIDTH_EQ_MIN = 11'd60;
    localparam logic [10:0] WIDTH_EQ_MAX = 11'd175;
    localparam logic [10:0] WIDTH_HS_MIN = 11'd176;
    localparam logic [10:0] WIDTH_HS_MAX = 11'd700;
    localparam logic [10:0] WIDTH_VS_MIN = 11'd1000;
    localparam logic [10:0] WIDTH_VS_MAX = 11'd1700;

    localparam logic [3:0]  MIN_VSYNC_PULSES      = 4'd4;
    localparam logic [11:0] H_ALIGN               = 12'd311;
    localparam logic [11:0] BASE_PIXEL_X          = 12'd184;
    localparam logic [11:0] RESOLUTION_HORIZONTAL = 12'd560;
    localparam logic [11:0] BASE_LINE             = 12'd40;
    localparam logic [11:0] RESOLUTION_VERTICAL   = 12'd200;

    typedef enum logic [2:0] {
        PULSE_NONE,
        PULSE_EQ,
        PULSE_HSYNC,
        PULSE_VSYNC,
        PULSE_GLITCH
    } pulse_e;

    typedef struct packed {
        logic glitch;
        logic vsync;
        logic hsync;
        logic eq;
    } pulse_oh_t;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VSYNC_TRAIN,
        ST_POST_EQ,
        ST_ACTIVE
    } state_e;

    function automatic pulse_e classify_run(input logic [10:0] len);
        if (len >= WIDTH_EQ_MIN && len <= WIDTH_EQ_MAX) return PULSE_EQ;
        if (len >= WIDTH_HS_MIN && len <= WIDTH_HS_MAX) return PULSE_HSYNC;
        if (len >= WIDTH_VS_MIN && len <= WIDTH_VS_MAX) return PULSE_VSYNC;
        return PULSE_GLITCH;
    endfunction

    // Luma levels 3..7 map to pixel codes 1..5; sync/blank/black give 0.
    function automatic logic [3:0] pixel_code(input logic [3:0] level);
        if (level >= SIGNAL_LEVEL_DARK_GREY && level <= SIGNAL_LEVEL_BRIGHT_WHITE)
            return level - 4'd2;
        return 4'd0;
    endfunction

endpackage

// File: rtl/ntsc_sync_classifier.sv
// Measures zero-level runs and classifies each on its first nonzero sample.
// Ports: clk_i, rst_ni (sync, active low), level_i[3:0], pulse_o (one-hot, registered).
module ntsc_sync_classifier
    import ntsc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] level_i,
    output pulse_oh_t  pulse_o
);

    logic [10:0] run_q, run_d;
    pulse_oh_t   pulse_q, pulse_d;
    pulse_e      cls;

    always_comb begin
        run_d   = run_q;
        cls     = PULSE_NONE;
        pulse_d = '0;
        if (level_i == SIGNAL_LEVEL_SYNC) begin
            if (run_q != 11'h7FF) run_d = run_q + 11'd1;
        end else begin
            run_d = '0;
            // Falling out of a sync run: classify its length exactly once.
            if (run_q != '0) cls = classify_run(run_q);
        end
        case (cls)
            PULSE_EQ:     pulse_d.eq     = 1'b1;
            PULSE_HSYNC:  pulse_d.hsync  = 1'b1;
            PULSE_VSYNC:  pulse_d.vsync  = 1'b1;
            PULSE_GLITCH: pulse_d.glitch = 1'b1;
            default:      pulse_d        = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            run_q   <= '0;
            pulse_q <= '0;
        end else begin
            run_q   <= run_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/ntsc_sync_decoder.sv
// NTSC composite receiver: locks to the vertical sync train, tracks line/h position, recovers pixels.
// Ports: clk, reset_n, level_in[3:0]; sync/lock flags, field_line, pixel_x/y, pixel_data, sync_error.
module ntsc_sync_decoder
    import ntsc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  level_in,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        locked,
    output logic [9:0]  field_line,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        pixel_is_visible,
    output logic [3:0]  pixel_data,
    output logic        sync_error
);

    pulse_oh_t   pulse;
    state_e      state_q, state_d;
    logic [3:0]  vcount_q, vcount_d;
    logic [9:0]  line_q, line_d;
    logic [11:0] h_count_q, h_count_d;
    logic        locked_q, locked_d;
    logic        hs_q, hs_d, vs_q, vs_d, err_q, err_d;
    logic        vis_q, vis_d;
    logic [10:0] px_q, px_d, py_q, py_d;
    logic [3:0]  pd_q, pd_d;
    logic [11:0] hx, fl;
    logic [10:0] px_off, py_off;

    ntsc_sync_classifier u_cls (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .level_i (level_in),
        .pulse_o (pulse)
    );

    always_comb begin
        state_d   = state_q;
        vcount_d  = vcount_q;
        line_d    = line_q;
        locked_d  = locked_q;
        hs_d      = pulse.hsync;
        vs_d      = 1'b0;
        err_d     = pulse.glitch;
        h_count_d = h_count_q;

        unique case (1'b1)
            pulse.hsync:              h_count_d = H_ALIGN;
            pulse.eq, pulse.vsync:    h_count_d = '0;
            default: if (h_count_q != 12'hFFF) h_count_d = h_count_q + 12'd1;
        endcase

        // A full line period with no usable sync means the signal is gone.
        if (state_q != ST_SEARCH && h_count_q == 12'hFFF) begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: if (pulse.vsync) begin
                    state_d  = ST_VSYNC_TRAIN;
                    vcount_d = 4'd1;
                end
                ST_VSYNC_TRAIN: begin
                    if (pulse.vsync) begin
                        if (vcount_q != 4'hF) vcount_d = vcount_q + 4'd1;
                    end else if (pulse.eq) begin
                        if (vcount_q >= MIN_VSYNC_PULSES) begin
                            state_d  = ST_POST_EQ;
                            vs_d     = 1'b1;
                            locked_d = 1'b1;
                            line_d   = '0;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end else if (pulse.hsync) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_POST_EQ: begin
                    if (pulse.hsync) begin
                        state_d = ST_ACTIVE;
                        line_d  = 10'd1;
                    end else if (pulse.vsync) begin
                        state_d  = ST_VSYNC_TRAIN;
                        vcount_d = 4'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (pulse.hsync) begin
                        if (line_q != 10'h3FF) line_d = line_q + 10'd1;
                    end else if (pulse.vsync) begin
                        state_d  = ST_VSYNC_TRAIN;
                        vcount_d = 4'd1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Pixel stage works on the current registered position and raw level.
    assign hx     = {2'b00, h_count_q[11:2]};
    assign fl     = {2'b00, line_q};
    assign px_off = {1'b0, h_count_q[11:2]} - BASE_PIXEL_X[10:0];
    assign py_off = {1'b0, line_q} - BASE_LINE[10:0];

    always_comb begin
        vis_d = locked_q && (state_q == ST_ACTIVE)
             && (hx >= BASE_PIXEL_X)
             && (hx < BASE_PIXEL_X + RESOLUTION_HORIZONTAL)
             && (fl >= BASE_LINE)
             && (fl < BASE_LINE + RESOLUTION_VERTICAL);
        px_d = vis_d ? px_off : '0;
        py_d = vis_d ? py_off : '0;
        pd_d = vis_d ? pixel_code(level_in) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_SEARCH;
            vcount_q  <= '0;
            line_q    <= '0;
            h_count_q <= '0;
            locked_q  <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            err_q     <= 1'b0;
            vis_q     <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            pd_q      <= '0;
        end else begin
            state_q   <= state_d;
            vcount_q  <= vcount_d;
            line_q    <= line_d;
            h_count_q <= h_count_d;
            locked_q  <= locked_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            err_q     <= err_d;
            vis_q     <= vis_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pd_q      <= pd_d;
        end
    end

    assign h_sync_out       = hs_q;
    assign v_sync_out       = vs_q;
    assign locked           = locked_q;
    assign field_line       = line_q;
    assign pixel_x          = px_q;
    assign pixel_y          = py_q;
    assign pixel_is_visible = vis_q;
    assign pixel_data       = pd_q;
    assign sync_error       = err_q;

endmodule

// File: doc/ntsc_sync_decoder.md
Name: ntsc_sync_decoder

Overview:
Receive-side counterpart to the team's NTSC composite generator. Consumes the 4-bit composite signal level, one sample per clk at the generator's clock rate. Separates sync pulses by width, locks to the field's vertical sync train, and tracks horizontal position and field line. Recovers pixel coordinates and the 4-bit pixel code for the capture and loopback test path.

Parameters:
EQ_MIN, 60, min sync-run length classed as equalizing pulse (nominal 117)
EQ_MAX, 175, max EQ length
HS_MIN, 176, min run classed as horizontal sync tip (nominal 235)
HS_MAX, 700, max HSYNC length
VS_MIN, 1000, min run classed as vertical serration pulse (nominal 1353)
VS_MAX, 1700, max VSYNC length
MIN_VSYNC_PULSES, 4, long pulses required before lock
H_ALIGN, 311, h_count load value at HSYNC run end (aligns to generator horizontal count)
BASE_PIXEL_X, 184, first visible h_count[11:2]
RESOLUTION_HORIZONTAL, 560, visible width
BASE_LINE, 40, first visible field line
RESOLUTION_VERTICAL, 200, visible field lines

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
level_in  in  4  composite level sample (0 = SYNC, 1 = BLANK, 2 = BLACK ... 7 = BRIGHT_WHITE)
h_sync_out  out  1  one-cycle pulse on each HSYNC-class run end
v_sync_out  out  1  one-cycle pulse at end of vertical sync train
locked  out  1  decoder synchronised to a field
field_line  out  10  line index within field
pixel_x  out  11  visible x, 0 when not visible
pixel_y  out  11  visible y, 0 when not visible
pixel_is_visible  out  1  pixel_x/pixel_y/pixel_data valid
pixel_data  out  4  recovered pixel code
sync_error  out  1  one-cycle pulse on an unclassifiable sync run

Behaviour:
- Reset: takes effect at the clk edge while reset_n = 0. All outputs go to 0, state = SEARCH, sync_run = 0, h_count = 0, vcount = 0. Reset mid-field drops lock immediately.
- sync_run counter: 11-bit. Increments while level_in == 0 and saturates at 2047. Clears on any nonzero sample.
- Classification: occurs on the first nonzero sample after a zero run, using run length L. Result is one of EQ, HSYNC, VSYNC (L within the inclusive ranges above) or GLITCH (all other L). At most one event per cycle.
- h_count: 12-bit.
  - HSYNC event: h_count <= H_ALIGN.
  - EQ or VSYNC event: h_count <= 0.
  - Otherwise h_count increments, saturating at 4095.
- State machine:
  - SEARCH: VSYNC -> VSYNC_TRAIN, vcount = 1. Other events are ignored.
  - VSYNC_TRAIN, on VSYNC: vcount++ (saturating at 15).
  - VSYNC_TRAIN, on EQ with vcount >= MIN_VSYNC_PULSES: -> POST_EQ, v_sync_out = 1, locked = 1, field_line = 0.
  - VSYNC_TRAIN, on EQ with too few pulses, or on HSYNC: -> SEARCH.
  - POST_EQ: EQ stays. HSYNC -> ACTIVE, field_line = 1. VSYNC -> VSYNC_TRAIN, vcount = 1.
  - ACTIVE: HSYNC -> field_line++ (saturating at 1023). EQ stays. VSYNC -> VSYNC_TRAIN, vcount = 1. locked stays 1 until timeout.
  - GLITCH in any state: sync_error = 1 for one cycle. No state, line or h_count change; h_count keeps counting.
  - Timeout: h_count reaching 4095 in any state other than SEARCH -> SEARCH, locked = 0.
- h_sync_out: pulses on every HSYNC event in every state, in the same cycle the state update registers.
- Pixel path: registered, 1-cycle latency from level_in.
  - visible = locked AND state == ACTIVE AND BASE_PIXEL_X <= h_count[11:2] < BASE_PIXEL_X + RESOLUTION_HORIZONTAL AND BASE_LINE <= field_line < BASE_LINE + RESOLUTION_VERTICAL.
  - Comparisons are unsigned and widened to 12 bits (no wrap).
  - pixel_x = h_count[11:2] - BASE_PIXEL_X; pixel_y = field_line - BASE_LINE. Both are 0 when not visible.
  - pixel_data map: level 3 -> 1, 4 -> 2, 5 -> 3, 6 -> 4, 7 -> 5; all other levels -> 0. Forced 0 when not visible.

Decomposition:
- Shared package ntsc_pkg holds:
  - SIGNAL_LEVEL_* constants
  - WIDTH_* timing constants
  - the pulse-class enum (NONE, EQ, HSYNC, VSYNC, GLITCH)
  - the decoder state enum
- Natural sub-module: ntsc_sync_classifier, containing sync_run, edge detect and range compare, with a registered one-hot class output. It feeds the top-level FSM, h_count and pixel stage.

Test Plan:
1. reset_n = 0 for 3 cycles with level_in = 5 -> every output 0, locked = 0; release and hold level 1 -> no pulses.
2. Zero run of 20 cycles -> sync_error high exactly 1 cycle, state and field_line unchanged, no h_sync_out.
3. Six pulses of 1353 zeros / 235 ones, then 117 zeros -> v_sync_out 1 cycle after the EQ run ends, locked = 1, field_line = 0. Same sequence with only 2 long pulses -> locked stays 0.
4. After lock, a 235-zero run -> h_sync_out 1 cycle, field_line = 1, and h_count = 311 on the next cycle. 10 more HSYNCs at 3175-cycle spacing -> field_line = 11, no timeout.
5. At field_line = 40 with h_count[11:2] = 184, drive level 6 -> next cycle pixel_is_visible = 1, pixel_x = 0, pixel_y = 0, pixel_data = 4. Level 2 -> pixel_data 0. h_count[11:2] = 744 -> not visible, outputs 0.
6. Locked, then level 1 held 4096 cycles -> locked falls when h_count reaches 4095. A following 235-zero run gives h_sync_out = 1 but field_line unchanged and state SEARCH.
